led_sequencer: RTL and testbench
================================

# led_sequencer

Parametrised LED sequencing controller for the board-level user-interface path. A debounced active-low start button launches a timed walk of one lit LED across NUM_LEDS outputs, followed by an all-off dwell, with optional continuous looping, run direction selection and a debounced stop button. It generalises the fixed two-LED start/time/off sequencer to N channels with programmable dwell times and glitch-free button handling.

## Interface
Parameters:
- NUM_LEDS, 4, number of LED channels (2..16)
- CNT_W, 32, dwell/debounce counter width
- ON_TICKS, 100000000, clk cycles each LED stays lit (1..2^CNT_W-1)
- OFF_TICKS, 500000000, clk cycles of the all-off dwell after the last LED (1..2^CNT_W-1)
- DEBOUNCE_TICKS, 1000000, consecutive stable synchronised samples required to accept a button level change (1..2^CNT_W-1)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start_n  in  1  start button, active-low, asynchronous to clk
- stop_n  in  1  stop button, active-low, asynchronous to clk
- loop_en  in  1  1 = restart the sequence after the off dwell; sampled when the off dwell ends
- dir  in  1  0 = ascending (LED 0 first), 1 = descending (LED NUM_LEDS-1 first); sampled on accepted start
- leds  out  NUM_LEDS  registered; one-hot during STEP, all zero otherwise
- step_idx  out  $clog2(NUM_LEDS)  registered index of the lit LED; 0 outside STEP
- busy  out  1  registered; 1 in any state other than IDLE
- done  out  1  registered one-cycle pulse when the off dwell completes

## Operation
- Reset (reset low, async): state IDLE, leds=0, step_idx=0, busy=0, done=0, timer=0, sync flops=1, debounced levels=1, debounce counters=0, latched dir=0.
- Button path, identical per button: 2-flop synchroniser (reset to 1) -> debouncer holding stable level (reset 1). Counter increments on each edge where synchronised value differs from stable level, clears when equal. At the edge where it would reach DEBOUNCE_TICKS, stable level flips and counter clears. A 1->0 flip produces a one-cycle press pulse (start_p / stop_p) registered at that same edge. Release (0->1) produces no pulse.
- States: IDLE, STEP, OFF.
- IDLE: start_p and not stop_p -> STEP; latch dir; step_idx = 0 (dir=0) or NUM_LEDS-1 (dir=1); timer=0. start_p together with stop_p -> stay IDLE (stop wins).
- STEP: timer counts 0..ON_TICKS-1. At timer==ON_TICKS-1: if step_idx is the last index (NUM_LEDS-1 ascending, 0 descending) -> OFF, timer=0; else step_idx +1/-1, timer=0, stay STEP. stop_p in STEP -> OFF immediately, timer=0 (abort; the full OFF dwell still applies). start_p ignored.
- OFF: leds=0; timer counts 0..OFF_TICKS-1. At timer==OFF_TICKS-1: done=1 for one cycle; loop_en=1 -> STEP at first index of the latched dir; loop_en=0 -> IDLE. start_p and stop_p ignored.
- Timer compares are width CNT_W, unsigned; no wrap is reachable within legal parameters.
- leds = one-hot(step_idx) in STEP; updated on the same edge as state/step_idx.

## Timing
- Button low first sampled at edge k -> sync out after k+1 -> stable flip and press pulse after edge k+1+DEBOUNCE_TICKS -> STEP and leds valid after edge k+2+DEBOUNCE_TICKS.
- Glitch shorter than DEBOUNCE_TICKS synchronised cycles: no pulse.
- Each LED lit exactly ON_TICKS cycles; OFF dwell exactly OFF_TICKS cycles; full unaborted run busy for NUM_LEDS*ON_TICKS+OFF_TICKS cycles.
- done high in the first cycle after OFF exits (same edge as return to IDLE/STEP); busy drops on that same edge when loop_en=0.
- Holding start_n low yields a single start; a new start needs release and re-press (each debounced).
- Reset asserted mid-sequence: all outputs zero asynchronously; no done pulse; next run requires a fresh press after reset release.

## Test plan
Parameters NUM_LEDS=4, ON_TICKS=5, OFF_TICKS=3, DEBOUNCE_TICKS=4.
- Start press, dir=0, loop_en=0 -> leds 0001,0010,0100,1000 each 5 cycles from edge k+6, then 0000 for 3 cycles, done one pulse, busy low after 23 busy cycles.
- start_n glitch low for 3 cycles -> no pulse, stays IDLE; dir=1 real press -> leds 1000,0100,0010,0001, step_idx 3,2,1,0.
- stop press while leds=0100 -> leds 0000 on stop_p edge+1, 3-cycle OFF, done pulse, IDLE.
- loop_en=1 -> after OFF, leds=0001 on the done edge, repeating; drop loop_en mid-run -> ends in IDLE after current OFF.
- start and stop pressed simultaneously in IDLE -> stays IDLE, busy=0; start held low 100 cycles -> exactly one sequence.
- reset pulsed low while leds=0010 -> leds=0, busy=0, done=0 immediately; no activity until next press.

Source files
------------

// File: rtl/led_sequencer.sv
// Debounced start/stop buttons drive a timed one-hot walk across NUM_LEDS
// outputs, followed by an all-off dwell with optional looping.
module led_sequencer #(
  parameter int          NUM_LEDS       = 4,
  parameter int          CNT_W          = 32,
  parameter int unsigned ON_TICKS       = 100000000,
  parameter int unsigned OFF_TICKS      = 500000000,
  parameter int unsigned DEBOUNCE_TICKS = 1000000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start_n,
  input  logic                        stop_n,
  input  logic                        loop_en,
  input  logic                        dir,
  output logic [NUM_LEDS-1:0]         leds,
  output logic [$clog2(NUM_LEDS)-1:0] step_idx,
  output logic                        busy,
  output logic                        done
);

  localparam int IDX_W = $clog2(NUM_LEDS);
  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_TICKS - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_TICKS - 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_TICKS - 1);
  localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(NUM_LEDS - 1);

  typedef enum logic [1:0] {IDLE, STEP, OFF} state_t;

  // Button index 0 is start, index 1 is stop.
  logic [1:0]       sync1_q, sync2_q, stable_q, stable_d, press_q, press_d;
  logic [CNT_W-1:0] debCnt_q [2];
  logic [CNT_W-1:0] debCnt_d [2];

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  stepIdx_q, stepIdx_d;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic [NUM_LEDS-1:0] leds_q, leds_d;
  logic              busy_q, busy_d, done_q, done_d, dirLat_q, dirLat_d;
  logic              startP, stopP;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q     <= '1;
      sync2_q     <= '1;
      stable_q    <= '1;
      press_q     <= '0;
      debCnt_q[0] <= '0;
      debCnt_q[1] <= '0;
    end else begin
      sync1_q     <= {stop_n, start_n};
      sync2_q     <= sync1_q;
      stable_q    <= stable_d;
      press_q     <= press_d;
      debCnt_q[0] <= debCnt_d[0];
      debCnt_q[1] <= debCnt_d[1];
    end
  end

  // A level is accepted only after DEBOUNCE_TICKS consecutive differing samples.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      stable_d[i] = stable_q[i];
      press_d[i]  = 1'b0;
      debCnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (debCnt_q[i] == DEB_LAST) begin
          stable_d[i] = ~stable_q[i];
          press_d[i]  = stable_q[i];
        end else begin
          debCnt_d[i] = debCnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign startP = press_q[0];
  assign stopP  = press_q[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      stepIdx_q <= '0;
      timer_q   <= '0;
      leds_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dirLat_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      stepIdx_q <= stepIdx_d;
      timer_q   <= timer_d;
      leds_q    <= leds_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dirLat_q  <= dirLat_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    stepIdx_d = stepIdx_q;
    timer_d   = timer_q;
    dirLat_d  = dirLat_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        stepIdx_d = '0;
        timer_d   = '0;
        if (startP && !stopP) begin
          state_d   = STEP;
          dirLat_d  = dir;
          stepIdx_d = dir ? IDX_MAX : '0;
        end
      end
      STEP: begin
        if (stopP) begin
          state_d   = OFF;
          stepIdx_d = '0;
          timer_d   = '0;
        end else if (timer_q == ON_LAST) begin
          timer_d = '0;
          if (stepIdx_q == (dirLat_q ? '0 : IDX_MAX)) begin
            state_d   = OFF;
            stepIdx_d = '0;
          end else begin
            stepIdx_d = dirLat_q ? stepIdx_q - IDX_W'(1) : stepIdx_q + IDX_W'(1);
          end
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      OFF: begin
        stepIdx_d = '0;
        if (timer_q == OFF_LAST) begin
          done_d  = 1'b1;
          timer_d = '0;
          if (loop_en) begin
            state_d   = STEP;
            stepIdx_d = dirLat_q ? IDX_MAX : '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    leds_d = (state_d == STEP) ? (NUM_LEDS'(1) << stepIdx_d) : '0;
    busy_d = (state_d != IDLE);
  end

  assign leds     = leds_q;
  assign step_idx = stepIdx_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer with short dwell and debounce times so
// every cycle of a run can be compared against hand-derived schedules.
module tb_led_sequencer;

  localparam int NUM_LEDS = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start_n = 1'b1;
  logic       stop_n = 1'b1;
  logic       loop_en = 1'b0;
  logic       dir = 1'b0;
  logic [3:0] leds;
  logic [1:0] step_idx;
  logic       busy;
  logic       done;

  int checkCount = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  led_sequencer #(
    .NUM_LEDS(NUM_LEDS),
    .CNT_W(32),
    .ON_TICKS(5),
    .OFF_TICKS(3),
    .DEBOUNCE_TICKS(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start_n(start_n),
    .stop_n(stop_n),
    .loop_en(loop_en),
    .dir(dir),
    .leds(leds),
    .step_idx(step_idx),
    .busy(busy),
    .done(done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkState(input string tag, input logic [3:0] eLeds, input logic [1:0] eIdx,
                            input logic eBusy, input logic eDone);
    checkOutput({tag, " leds"}, 32'(leds), 32'(eLeds));
    checkOutput({tag, " step_idx"}, 32'(step_idx), 32'(eIdx));
    checkOutput({tag, " busy"}, 32'(busy), 32'(eBusy));
    checkOutput({tag, " done"}, 32'(done), 32'(eDone));
  endtask

  task automatic applyStimulus(input logic sN, input logic pN, input logic lE, input logic d);
    start_n = sN;
    stop_n  = pN;
    loop_en = lE;
    dir     = d;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // r counts cycles from the first STEP cycle; each LED holds for 5 cycles.
  function automatic logic [3:0] expLeds(input int r, input logic desc);
    if (r >= 20) return 4'b0000;
    return desc ? (4'b1000 >> (r / 5)) : (4'b0001 << (r / 5));
  endfunction

  function automatic logic [1:0] expIdx(input int r, input logic desc);
    if (r >= 20) return 2'd0;
    return desc ? 2'(3 - r / 5) : 2'(r / 5);
  endfunction

  initial begin
    int r;
    int busySeen;
    int doneCount;
    int busyCount;

    waitCycles(2);
    checkState("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    reset = 1'b1;
    waitCycles(3);

    // Ascending run with no loop.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    waitCycles(6);
    checkState("asc pre", 4'b0000, 2'd0, 1'b0, 1'b0);
    for (int c = 0; c < 25; c++) begin
      waitCycles(1);
      checkState($sformatf("asc c%0d", c), expLeds(c, 1'b0), expIdx(c, 1'b0), c < 23, c == 23);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    waitCycles(12);

    // Three-cycle glitch must not start, then a real descending press.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    waitCycles(3);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    busySeen = 0;
    for (int i = 0; i < 15; i++) begin
      waitCycles(1);
      busySeen += int'(busy);
    end
    checkOutput("glitch busy", 32'(busySeen), 32'd0);
    checkOutput("glitch leds", 32'(leds), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    waitCycles(6);
    checkState("desc pre", 4'b0000, 2'd0, 1'b0, 1'b0);
    for (int c = 0; c < 25; c++) begin
      waitCycles(1);
      checkState($sformatf("desc c%0d", c), expLeds(c, 1'b1), expIdx(c, 1'b1), c < 23, c == 23);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    waitCycles(12);

    // Stop pressed so the abort lands while LED 2 is lit.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    for (int n = 1; n <= 23; n++) begin
      waitCycles(1);
      if (n >= 7) begin
        r = n - 7;
        checkState($sformatf("abort c%0d", r),
                   (r < 12) ? expLeds(r, 1'b0) : 4'b0000,
                   (r < 12) ? expIdx(r, 1'b0) : 2'd0,
                   r < 15, r == 15);
      end
      if (n == 12) stop_n = 1'b0;
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    waitCycles(12);

    // Looping run; loop_en dropped partway through the second pass.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    waitCycles(6);
    for (int c = 0; c < 48; c++) begin
      waitCycles(1);
      r = c % 23;
      checkState($sformatf("loop c%0d", c),
                 (c < 46) ? expLeds(r, 1'b0) : 4'b0000,
                 (c < 46) ? expIdx(r, 1'b0) : 2'd0,
                 c < 46, (c == 23) || (c == 46));
      if (c == 30) loop_en = 1'b0;
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    waitCycles(12);

    // Simultaneous start and stop: stop wins.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    busySeen = 0;
    for (int i = 0; i < 20; i++) begin
      waitCycles(1);
      busySeen += int'(busy);
    end
    checkOutput("simul busy", 32'(busySeen), 32'd0);
    checkOutput("simul leds", 32'(leds), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    waitCycles(12);

    // Start held for 100 cycles yields exactly one run.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    doneCount = 0;
    busyCount = 0;
    for (int i = 0; i < 100; i++) begin
      waitCycles(1);
      doneCount += int'(done);
      busyCount += int'(busy);
    end
    checkOutput("held done count", 32'(doneCount), 32'd1);
    checkOutput("held busy cycles", 32'(busyCount), 32'd23);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    waitCycles(12);

    // Asynchronous reset while LED 1 is lit.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    waitCycles(6);
    for (int c = 0; c < 8; c++) begin
      waitCycles(1);
      if (c == 1) start_n = 1'b1;
    end
    checkState("pre-reset", 4'b0010, 2'd1, 1'b1, 1'b0);
    #2 reset = 1'b0;
    #1 checkState("async reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    waitCycles(1);
    reset = 1'b1;
    busySeen = 0;
    for (int i = 0; i < 30; i++) begin
      waitCycles(1);
      busySeen += int'(busy) + int'(done);
    end
    checkOutput("post-reset idle", 32'(busySeen), 32'd0);
    checkOutput("post-reset leds", 32'(leds), 32'd0);

    $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
    $finish;
  end

endmodule
